round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter COUNTDOWN_TICKS, default 3: ticks spent in COUNTDOWN before play starts (1..15).
REQ-002 Parameter BEATS_PER_ROUND, default 16: spawn beats issued per round (1..63).
REQ-003 Parameter DRAIN_TICKS, default 4: ticks after the last beat before the round ends, letting falling blocks reach the line (0..15).
REQ-004 Parameter WIN_SCORE, default 20: score that ends the round early (1..31).
REQ-005 Port clk  in  1: single clock; every register is on its rising edge.
REQ-006 Port reset  in  1: asynchronous, active-high reset.
REQ-007 Port start  in  1: synchronous level from the start button.
REQ-008 Port tick  in  1: one-cycle game-beat strobe.
REQ-009 Port hit1, hit2  in  1 each: one-cycle pulses, one per successful player hit.
REQ-010 Port phase  out  2: 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 RESULT.
REQ-011 Port spawn  out  1: one-cycle pulse that requests new blocks.
REQ-012 Port spawn_lane  out  2: lanes to spawn, with bit0 = lane 1 and bit1 = lane 2; valid while spawn=1.
REQ-013 Port score1, score2  out  5 each: player scores.
REQ-014 Port winner  out  2: 00 undecided, 01 player 1, 10 player 2, 11 tie.

Function
REQ-015 start_edge SHALL be start & ~start_q; start_q is a register of start.
REQ-016 IDLE -> COUNTDOWN on start_edge, with score1, score2, the tick counter and the beat counter cleared in that same cycle.
REQ-017 COUNTDOWN counts ticks and moves to PLAY on the cycle the COUNTDOWN_TICKS-th tick is sampled.
REQ-018 In PLAY, while beats issued < BEATS_PER_ROUND, each sampled tick SHALL produce spawn=1 exactly one cycle later and increment the beat counter.
REQ-019 After BEATS_PER_ROUND beats, spawn SHALL stay 0; after DRAIN_TICKS further ticks the FSM enters RESULT. With DRAIN_TICKS=0 it enters RESULT on the cycle after the last beat.
REQ-020 In PLAY, each hitN pulse increments scoreN by 1, saturating at 31; simultaneous hit1 and hit2 are both counted.
REQ-021 hit1/hit2 SHALL be ignored in IDLE, COUNTDOWN and RESULT.
REQ-022 If either score reaches WIN_SCORE, the FSM enters RESULT on the next cycle, even mid-beat or mid-drain; no further spawn is issued.
REQ-023 winner SHALL be registered on entry to RESULT from the final scores (01 if score1>score2, 10 if score2>score1, 11 if equal), held throughout RESULT, and be 00 in every other phase.
REQ-024 RESULT -> COUNTDOWN on start_edge (scores cleared, winner back to 00); start_edge in COUNTDOWN or PLAY SHALL be ignored.
REQ-025 spawn_lane SHALL never be 00 while spawn=1.
REQ-026 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-027 On reset assertion: phase=IDLE, spawn=0, spawn_lane=00, score1=score2=0, winner=00, all counters 0, start_q=1 (a start held through reset causes no edge), LFSR=8'hA5.
REQ-028 Reset mid-round SHALL abort immediately to the reset state; the first start_edge after release begins a fresh countdown.

Configuration
REQ-029 Macro ROUND_SEQ_LFSR_PATTERN_EN defined: spawn_lane = LFSR[1:0], or 11 when those bits are 00. The LFSR is 8-bit Fibonacci with taps 8,6,5,4 and steps once per issued spawn.
REQ-030 Macro ROUND_SEQ_LFSR_PATTERN_EN undefined: spawn_lane cycles 01, 10, 11, 01, ... starting at 01 each round, and no LFSR is built.

Verification
REQ-031 Default parameters, start pulse, then 3 ticks -> phase 1 then 2; the 4th tick gives spawn=1 exactly one cycle later.
REQ-032 Full round with 16 ticks in PLAY and no hits, then 4 more ticks -> exactly 16 spawn pulses, then phase=3 with winner=11.
REQ-033 hit1 and hit2 in the same cycle, 5 times, plus one extra hit2 -> score1=5, score2=6; at round end winner=10.
REQ-034 WIN_SCORE=3, three hit1 pulses at beat 5 -> phase=3 on the cycle after the third hit, score1=3, winner=01, no further spawn.
REQ-035 Reset asserted during PLAY while start is held high, then released -> all outputs at reset values and phase stays 0 until start drops and rises again.
REQ-036 Without ROUND_SEQ_LFSR_PATTERN_EN -> the first four spawn_lane values are 01, 10, 11, 01; with it defined -> spawn_lane matches a reference LFSR seeded 8'hA5 and is never 00.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller (IDLE -> COUNTDOWN -> PLAY -> RESULT).
// Counts down, issues one spawn beat per tick, keeps per-player scores,
// ends the round on beat exhaustion plus drain or on a winning score, and
// latches the winner.
// Optional build macro ROUND_SEQ_LFSR_PATTERN_EN: spawn lanes come from an
// 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) instead of the fixed
// 01,10,11 rotation.
module round_sequencer #(
  parameter int COUNTDOWN_TICKS = 3,
  parameter int BEATS_PER_ROUND = 16,
  parameter int DRAIN_TICKS     = 4,
  parameter int WIN_SCORE       = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       hit1,
  input  logic       hit2,
  output logic [1:0] phase,
  output logic       spawn,
  output logic [1:0] spawn_lane,
  output logic [4:0] score1,
  output logic [4:0] score2,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    RESULT    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       start_q;
  logic       start_edge;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [5:0] beat_cnt_q, beat_cnt_d;
  logic       spawn_q, spawn_d;
  logic [1:0] lane_q, lane_d;
  logic [4:0] score1_q, score1_d;
  logic [4:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic [4:0] s1_hit, s2_hit;
  logic [1:0] next_lane;

  // Increment a 5-bit score by one, holding at 31.
  function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic inc);
    if (inc && (v != 5'd31)) return v + 5'd1;
    return v;
  endfunction

  // Winner code from final scores: 01 p1 ahead, 10 p2 ahead, 11 tie.
  function automatic logic [1:0] decide(input logic [4:0] a, input logic [4:0] b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b11;
  endfunction

  assign start_edge = start & ~start_q;

`ifdef ROUND_SEQ_LFSR_PATTERN_EN
  logic [7:0] lfsr_q;
  assign next_lane = (lfsr_q[1:0] == 2'b00) ? 2'b11 : lfsr_q[1:0];

  // LFSR advances once per issued spawn and runs freely across rounds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        lfsr_q <= 8'hA5;
    else if (spawn_d) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  logic [1:0] pat_q;
  assign next_lane = pat_q + 2'd1;

  // Lane rotation index 0,1,2; rewound during every countdown so each round starts at 01.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       pat_q <= 2'd0;
    else if (state_q == COUNTDOWN)   pat_q <= 2'd0;
    else if (spawn_d)                pat_q <= (pat_q == 2'd2) ? 2'd0 : pat_q + 2'd1;
  end
`endif

  // Next-state and registered-output computation for the round FSM.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    beat_cnt_d = beat_cnt_q;
    spawn_d    = 1'b0;
    lane_d     = lane_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    winner_d   = winner_q;
    s1_hit     = sat_inc(score1_q, hit1);
    s2_hit     = sat_inc(score2_q, hit2);
    case (state_q)
      IDLE, RESULT: begin
        if (start_edge) begin
          state_d    = COUNTDOWN;
          tick_cnt_d = 4'd0;
          beat_cnt_d = 6'd0;
          score1_d   = 5'd0;
          score2_d   = 5'd0;
          winner_d   = 2'b00;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (int'(tick_cnt_q) + 1 >= COUNTDOWN_TICKS) begin
            state_d    = PLAY;
            tick_cnt_d = 4'd0;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      PLAY: begin
        score1_d = s1_hit;
        score2_d = s2_hit;
        // A winning score preempts everything else, including a coincident tick.
        if ((int'(s1_hit) >= WIN_SCORE) || (int'(s2_hit) >= WIN_SCORE)) begin
          state_d  = RESULT;
          winner_d = decide(s1_hit, s2_hit);
        end else if (int'(beat_cnt_q) < BEATS_PER_ROUND) begin
          if (tick) begin
            spawn_d    = 1'b1;
            lane_d     = next_lane;
            beat_cnt_d = beat_cnt_q + 6'd1;
          end
        end else if (DRAIN_TICKS == 0) begin
          state_d  = RESULT;
          winner_d = decide(s1_hit, s2_hit);
        end else if (tick) begin
          if (int'(tick_cnt_q) + 1 >= DRAIN_TICKS) begin
            state_d  = RESULT;
            winner_d = decide(s1_hit, s2_hit);
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers; start_q resets high so a held button is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b1;
      tick_cnt_q <= 4'd0;
      beat_cnt_q <= 6'd0;
      spawn_q    <= 1'b0;
      lane_q     <= 2'b00;
      score1_q   <= 5'd0;
      score2_q   <= 5'd0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      tick_cnt_q <= tick_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      spawn_q    <= spawn_d;
      lane_q     <= lane_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      winner_q   <= winner_d;
    end
  end

  assign phase      = state_q;
  assign spawn      = spawn_q;
  assign spawn_lane = lane_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: two instances (WIN_SCORE 20 and 3) share the
// same stimulus and are each compared every cycle against a behavioural
// round model, plus directed checks for the key round scenarios.
module tb_round_sequencer;

  localparam int CD    = 3;
  localparam int BEATS = 16;
  localparam int DRAIN = 4;
  localparam int WIN_A = 20;
  localparam int WIN_B = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start = 1'b0, tick = 1'b0, hit1 = 1'b0, hit2 = 1'b0;
  logic [1:0] phase_a, lane_a, winner_a, phase_b, lane_b, winner_b;
  logic       spawn_a, spawn_b;
  logic [4:0] s1_a, s2_a, s1_b, s2_b;

  int n_checks = 0;
  int n_pass   = 0;
  int spawns_a = 0;
  int spawns_b = 0;
  logic [1:0] lanes_a[$];

  typedef struct packed {
    int phase; int cnt; int beats; int s1; int s2; int win;
    int startq; int spawn; int lane; int nsp; int lfsr;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  round_sequencer #(.COUNTDOWN_TICKS(CD), .BEATS_PER_ROUND(BEATS),
                    .DRAIN_TICKS(DRAIN), .WIN_SCORE(WIN_A)) dut_a (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .hit1(hit1), .hit2(hit2),
    .phase(phase_a), .spawn(spawn_a), .spawn_lane(lane_a),
    .score1(s1_a), .score2(s2_a), .winner(winner_a));

  round_sequencer #(.COUNTDOWN_TICKS(CD), .BEATS_PER_ROUND(BEATS),
                    .DRAIN_TICKS(DRAIN), .WIN_SCORE(WIN_B)) dut_b (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .hit1(hit1), .hit2(hit2),
    .phase(phase_b), .spawn(spawn_b), .spawn_lane(lane_b),
    .score1(s1_b), .score2(s2_b), .winner(winner_b));

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) & 255) | fb;
  endfunction

  // Lane expected for the next spawn, given spawns so far this round / LFSR state.
  function automatic int lane_of(input mdl_t m);
`ifdef ROUND_SEQ_LFSR_PATTERN_EN
    return ((m.lfsr % 4) == 0) ? 3 : (m.lfsr % 4);
`else
    return (m.nsp % 3) + 1;
`endif
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.startq = 1;
    m.lfsr   = 8'hA5;
    return m;
  endfunction

  function automatic int judge(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  // One clock of the round rules applied to the inputs sampled at that edge.
  function automatic mdl_t mdl_step(input mdl_t m, input int win_sc,
                                    input logic st, input logic tk,
                                    input logic h1, input logic h2);
    mdl_t n;
    bit   es;
    int   a, b;
    n       = m;
    es      = st && (m.startq == 0);
    n.startq = st ? 1 : 0;
    n.spawn  = 0;
    if ((m.phase == 0 || m.phase == 3) && es) begin
      n.phase = 1; n.cnt = 0; n.beats = 0; n.s1 = 0; n.s2 = 0; n.win = 0; n.nsp = 0;
    end else if (m.phase == 1) begin
      if (tk) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == CD) begin n.phase = 2; n.cnt = 0; end
      end
    end else if (m.phase == 2) begin
      a = m.s1 + (h1 ? 1 : 0); if (a > 31) a = 31;
      b = m.s2 + (h2 ? 1 : 0); if (b > 31) b = 31;
      n.s1 = a; n.s2 = b;
      if (a >= win_sc || b >= win_sc) begin
        n.phase = 3; n.win = judge(a, b);
      end else if (m.beats < BEATS) begin
        if (tk) begin
          n.spawn = 1; n.lane = lane_of(m); n.nsp = m.nsp + 1;
          n.lfsr = lfsr_next(m.lfsr); n.beats = m.beats + 1;
        end
      end else if (DRAIN == 0) begin
        n.phase = 3; n.win = judge(a, b);
      end else if (tk) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == DRAIN) begin n.phase = 3; n.win = judge(a, b); end
      end
    end
    return n;
  endfunction

  task automatic cmp_all(input string who, input mdl_t m, input logic [1:0] ph,
                         input logic sp, input logic [1:0] ln, input logic [4:0] a,
                         input logic [4:0] b, input logic [1:0] w);
    check_val({who, ".phase"}, int'(ph), m.phase);
    check_val({who, ".spawn"}, int'(sp), m.spawn);
    if (m.spawn != 0) begin
      check_val({who, ".lane"}, int'(ln), m.lane);
      check_val({who, ".lane_nonzero"}, int'(ln != 2'b00), 1);
    end
    check_val({who, ".score1"}, int'(a), m.s1);
    check_val({who, ".score2"}, int'(b), m.s2);
    check_val({who, ".winner"}, int'(w), m.win);
  endtask

  task automatic cmp_both(input string tag);
    cmp_all({tag, ".a"}, ma, phase_a, spawn_a, lane_a, s1_a, s2_a, winner_a);
    cmp_all({tag, ".b"}, mb, phase_b, spawn_b, lane_b, s1_b, s2_b, winner_b);
  endtask

  task automatic cyc(input logic st, input logic tk, input logic h1, input logic h2);
    start = st; tick = tk; hit1 = h1; hit2 = h2;
    @(posedge clk);
    ma = mdl_step(ma, WIN_A, st, tk, h1, h2);
    mb = mdl_step(mb, WIN_B, st, tk, h1, h2);
    #1;
    if (spawn_a) begin spawns_a++; lanes_a.push_back(lane_a); end
    if (spawn_b) spawns_b++;
    cmp_both("cyc");
  endtask

  task automatic gap(input int maxg);
    int g;
    g = $urandom_range(maxg, 0);
    for (int i = 0; i < g; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      gap(2);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    #2;
    cmp_both("rst_async");
    @(posedge clk);
    #1;
    cmp_both("rst_held");
    reset = 1'b0;
  endtask

  initial begin
    int r;
    int bound;
    int exp_lane;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_both("por");
    reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Round 1: countdown, 16 beats without hits, drain, tie.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("r1.countdown", int'(phase_a), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CD; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("r1.phase_after_tick", int'(phase_a), (i == CD - 1) ? 2 : 1);
      gap(2);
    end
    spawns_a = 0;
    lanes_a.delete();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("r1.spawn_latency", int'(spawn_a), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("r1.spawn_one_cycle", int'(spawn_a), 0);
    ticks(BEATS - 1);
    check_val("r1.still_play", int'(phase_a), 2);
    ticks(DRAIN);
    check_val("r1.spawn_count", spawns_a, BEATS);
    check_val("r1.result", int'(phase_a), 3);
    check_val("r1.winner_tie", int'(winner_a), 3);
    r = 8'hA5;
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_SEQ_LFSR_PATTERN_EN
      exp_lane = ((r % 4) == 0) ? 3 : (r % 4);
      r = lfsr_next(r);
`else
      exp_lane = (k % 3) + 1;
`endif
      check_val("r1.first_lanes", (lanes_a.size() > k) ? int'(lanes_a[k]) : 0, exp_lane);
    end

    // Round 2: five simultaneous hits plus one extra hit2.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("r2.restart", int'(phase_a), 1);
    check_val("r2.winner_cleared", int'(winner_a), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(CD);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'($urandom_range(1, 0)), 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("r2.score1", int'(s1_a), 5);
    check_val("r2.score2", int'(s2_a), 6);
    check_val("r2.b_tie_at_3", int'(winner_b), 3);
    bound = 0;
    while (phase_a != 2'd3 && bound < 200) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      bound++;
    end
    check_val("r2.round_ended", int'(phase_a), 3);
    check_val("r2.winner_p2", int'(winner_a), 2);

    // Round 3: early win in the WIN_SCORE=3 instance at beat 5.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(CD);
    ticks(5);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      if (i < 2) begin
        check_val("r3.not_yet", int'(phase_b), 2);
        gap(2);
      end
    end
    check_val("r3.early_result", int'(phase_b), 3);
    check_val("r3.score1", int'(s1_b), 3);
    check_val("r3.winner_p1", int'(winner_b), 1);
    spawns_b = 0;
    ticks(4);
    check_val("r3.no_spawn_after_win", spawns_b, 0);

    // Reset during PLAY with start held high.
    check_val("rst.in_play", int'(phase_a), 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      check_val("rst.no_edge", int'(phase_a), 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst.fresh_start", int'(phase_a), 1);

    // Randomized play against the model.
    for (int i = 0; i < 1200; i++) begin
      logic st;
      st = ($urandom_range(19, 0) == 0) ? ~start : start;
      cyc(st, 1'($urandom_range(2, 0) == 0), 1'($urandom_range(4, 0) == 0),
          1'($urandom_range(4, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
